// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared accumulator constants and the clocked-action decode
package alu_pkg;

  localparam int ACC_W_DEF = 8;
  localparam int STEPS_MAX = 255;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_SHR,
    OP_SHL
  } acc_op_e;

  // Clear beats load, load beats any shift, right shift beats left shift.
  function automatic acc_op_e decode_op(input logic c0, input logic c2,
                                        input logic c3, input logic c4);
    if (c0)      return OP_CLR;
    else if (c2) return OP_LOAD;
    else if (c4) return OP_SHR;
    else if (c3) return OP_SHL;
    else         return OP_HOLD;
  endfunction

endpackage

// File: rtl/acc_reg_if.sv
// rtl/acc_reg_if.sv - control, data and status bundle of the accumulator register
interface acc_reg_if #(
  parameter int W = 8
);
  logic         c0;
  logic         c2;
  logic         c3;
  logic         c4;
  logic         c5;
  logic         ser_in;
  logic [W-1:0] sum;
  logic [W-1:0] q;
  logic         lsb_out;
  logic         msb_out;
  logic         done;

  modport master (
    output c0, c2, c3, c4, c5, ser_in, sum,
    input  q, lsb_out, msb_out, done
  );

  modport slave (
    input  c0, c2, c3, c4, c5, ser_in, sum,
    output q, lsb_out, msb_out, done
  );
endinterface

// File: rtl/step_cnt.sv
// rtl/step_cnt.sv - saturating shift-step counter; done flags cnt == STEPS
module step_cnt
  import alu_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int STEPS_C = (STEPS > STEPS_MAX) ? STEPS_MAX : ((STEPS < 1) ? 1 : STEPS);
  localparam int CW = $clog2(STEPS_C + 1);
  localparam logic [CW-1:0] TOP = CW'(STEPS_C);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != TOP))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == TOP);

endmodule

// File: rtl/acc_reg.sv
// rtl/acc_reg.sv - shifting accumulator with tri-state read port
// Define ACC_REG_STEP_CNT_EN to build the step counter; otherwise done is tied low.
module acc_reg
  import alu_pkg::*;
#(
  parameter int W     = ACC_W_DEF,
  parameter int STEPS = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  acc_reg_if.slave     bus,
  output wire  [W-1:0] obus
);

  logic [W-1:0] q_q, q_d;
  logic         lsb_q, lsb_d;
  logic         msb_q, msb_d;
  logic         done_w;
  acc_op_e      op;

  assign op = decode_op(bus.c0, bus.c2, bus.c3, bus.c4);

  always_comb begin
    q_d   = q_q;
    lsb_d = lsb_q;
    msb_d = msb_q;
    case (op)
      OP_CLR: begin
        q_d   = '0;
        lsb_d = 1'b0;
        msb_d = 1'b0;
      end
      OP_LOAD: q_d = bus.sum;
      OP_SHR: begin
        q_d   = {q_q[W-1], q_q[W-1:1]};
        lsb_d = q_q[0];
      end
      OP_SHL: begin
        q_d   = {q_q[W-2:0], bus.ser_in};
        msb_d = q_q[W-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q   <= '0;
      lsb_q <= 1'b0;
      msb_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      lsb_q <= lsb_d;
      msb_q <= msb_d;
    end
  end

`ifdef ACC_REG_STEP_CNT_EN
  logic cnt_clr, cnt_inc;
  assign cnt_clr = (op == OP_CLR);
  assign cnt_inc = (op == OP_SHR) || (op == OP_SHL);

  step_cnt #(
    .STEPS (STEPS)
  ) u_step_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .done  (done_w)
  );
`else
  assign done_w = 1'b0;
`endif

  assign bus.q       = q_q;
  assign bus.lsb_out = lsb_q;
  assign bus.msb_out = msb_q;
  assign bus.done    = done_w;

  // Reset does not gate the read port; it simply shows the cleared register.
  assign obus = bus.c5 ? q_q : {W{1'bz}};

endmodule

// File: doc/acc_reg.md
ACC_REG -- requirements
Module: acc_reg

Interface
REQ-001 Parameter W, default 8: data width of the accumulator, obus and sum; legal range 2..64.
REQ-002 Parameter STEPS, default 8: shift count at which done asserts; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 c0  input  1  synchronous clear of accumulator and step counter.
REQ-006 c2  input  1  load sum into accumulator.
REQ-007 c3  input  1  shift left one bit, with ser_in entering at bit 0.
REQ-008 c4  input  1  arithmetic shift right one bit, with the MSB replicated.
REQ-009 c5  input  1  drive obus with the accumulator value.
REQ-010 ser_in  input  1  serial bit for left shifts.
REQ-011 sum  input  W  parallel load data from the adder.
REQ-012 q  output  W  accumulator contents.
REQ-013 obus  output  W  tri-state bus output.
REQ-014 lsb_out  output  1  registered bit shifted out by the last right shift.
REQ-015 msb_out  output  1  registered bit shifted out by the last left shift.
REQ-016 done  output  1  step counter has reached STEPS.

Function
REQ-017 Clocked actions SHALL be prioritised as c0 > c2 > c4 > c3; exactly one action is taken per cycle, and no action leaves all state held.
REQ-018 c0: q, lsb_out, msb_out and cnt SHALL become 0 on the next edge.
REQ-019 c2: q SHALL become sum; cnt, lsb_out and msb_out SHALL hold.
REQ-020 c4: q SHALL become {q[W-1], q[W-1:1]}, lsb_out SHALL become the old q[0], and cnt SHALL increment.
REQ-021 c3: q SHALL become {q[W-2:0], ser_in}, msb_out SHALL become the old q[W-1], and cnt SHALL increment.
REQ-022 When c3 and c4 are both asserted, only the right shift SHALL occur; cnt SHALL increment once.
REQ-023 cnt SHALL saturate at STEPS; further shifts still shift q but do not change cnt.
REQ-024 done SHALL equal (cnt == STEPS), combinational from the registered cnt, so it is valid in the cycle after the STEPS-th shift edge.
REQ-025 obus SHALL equal q while c5 is high and be all-Z (full W bits) otherwise; the path is combinational with zero latency.
REQ-026 A c2 in the same cycle as a shift SHALL suppress the shift, and cnt SHALL not increment.

Reset
REQ-027 rst_b low SHALL immediately force q=0, cnt=0, lsb_out=0, msb_out=0 and done=0, independent of clk.
REQ-028 Reset asserted mid-sequence SHALL abandon the count; the first edge after release SHALL behave as from a fresh clear.
REQ-029 obus SHALL remain controlled only by c5 during reset; it reads 0 if c5 is high.

Configuration
REQ-030 Macro ACC_REG_STEP_CNT_EN defined: the step counter and done SHALL be implemented as specified above.
REQ-031 Macro ACC_REG_STEP_CNT_EN undefined: no counter registers SHALL exist, done SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package alu_pkg SHALL hold the default data width constant (8) and the maximum step count constant (255).
REQ-033 The counter SHALL be a sub-module step_cnt (parameter STEPS; ports clk, rst_b, clr, inc, done), instantiated only under ACC_REG_STEP_CNT_EN.
REQ-034 The counter width SHALL be $clog2(STEPS+1).

Verification
REQ-035 Sequence: rst_b low, then high, then c5=1 -> q=0x00, obus=0x00, done=0; with c5=0, obus=Z.
REQ-036 Sequence: c2 with sum=0x96, then c4 for one cycle -> q=0xCB, lsb_out=0; a second c4 -> q=0xE5, lsb_out=1.
REQ-037 Sequence: q=0x81, ser_in=1, c3 -> q=0x03, msb_out=1, cnt=1.
REQ-038 Sequence: c0 then 8 cycles of c4 (W=STEPS=8) -> done rises after the 8th edge; a 9th c4 -> cnt stays 8, q still shifts.
REQ-039 Sequence: c0, c2 and c4 asserted together with sum=0x55 -> q=0, cnt=0; next cycle c2+c4 with sum=0x55 -> q=0x55, cnt=0.
REQ-040 Sequence: after 5 shifts, pulse rst_b low between clock edges -> q=0 and done=0 immediately; rerun with W=16, STEPS=16, and without ACC_REG_STEP_CNT_EN -> done is always 0.
